// File: rtl/hier_node_pkg.sv
// Shared constants and helpers for the hierarchy-node arbiter.
package hier_node_pkg;

   localparam int STAT_W = 16;

   // Index width that never collapses to zero bits, even for a single child.
   function automatic int clog2_min1(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/hier_rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus encoded index, priority rotating past the last winner.
module hier_rr_arbiter #(
   parameter int N     = 5,
   parameter int IDX_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     req_i,
   input  logic             en_i,
   output logic [N-1:0]     gnt_o,
   output logic [IDX_W-1:0] idx_o
);

   logic [IDX_W-1:0] last_q, last_d;
   logic [IDX_W-1:0] k;
   logic             found;

   // NOTE: every output and temporary gets a default before the search loop so
   // no path leaves a value unassigned, which would infer a latch.
   always_comb begin
      gnt_o  = '0;
      idx_o  = '0;
      found  = 1'b0;
      k      = '0;
      last_d = last_q;
      for (int i = 1; i <= N; i++) begin
         k = IDX_W'((int'(last_q) + i) % N);
         if (en_i && !found && req_i[k]) begin
            found    = 1'b1;
            gnt_o[k] = 1'b1;
            idx_o    = k;
         end
      end
      // A grant is always a transfer: ready is only raised for a valid child.
      if (found) last_d = idx_o;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) last_q <= IDX_W'(N - 1);
      else        last_q <= last_d;
   end

endmodule

// File: rtl/hier_node_arbiter.sv
// Hierarchy node: round-robin fan-in of child streams into a tagged output FIFO.
// Optional per-child grant counters are enabled by defining HIER_NODE_ARBITER_STATS_EN.
module hier_node_arbiter
   import hier_node_pkg::*;
#(
   parameter  int N_CHILDREN = 5,
   parameter  int DATA_W     = 8,
   parameter  int DEPTH      = 4,
   localparam int IDX_W      = clog2_min1(N_CHILDREN),
   localparam int LVL_W      = $clog2(DEPTH) + 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         en,
   input  logic [N_CHILDREN-1:0]        ch_valid,
   input  logic [N_CHILDREN*DATA_W-1:0] ch_data,
   output logic [N_CHILDREN-1:0]        ch_ready,
   output logic                         up_valid,
   output logic [DATA_W-1:0]            up_data,
   output logic [IDX_W-1:0]             up_idx,
   input  logic                         up_ready,
   output logic [LVL_W-1:0]             level,
   input  logic                         stat_clr,
   output logic [N_CHILDREN*STAT_W-1:0] stat_grant_cnt
);

   localparam int PTR_W = $clog2(DEPTH);

   typedef struct packed {
      logic [IDX_W-1:0]  idx;
      logic [DATA_W-1:0] data;
   } entry_t;

   entry_t           mem_q [DEPTH];
   entry_t           wr_entry;
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [LVL_W-1:0] level_q, level_d;
   logic [IDX_W-1:0] gnt_idx;
   logic             grant_en, push, pop;

   // Full blocks new grants even when a pop frees a slot in the same cycle.
   assign grant_en = en && (level_q < LVL_W'(DEPTH));

   hier_rr_arbiter #(
      .N     (N_CHILDREN),
      .IDX_W (IDX_W)
   ) u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req_i (ch_valid),
      .en_i  (grant_en),
      .gnt_o (ch_ready),
      .idx_o (gnt_idx)
   );

   assign push     = |(ch_valid & ch_ready);
   assign pop      = (level_q != '0) && up_ready;
   assign wr_entry = '{idx: gnt_idx, data: ch_data[int'(gnt_idx)*DATA_W +: DATA_W]};

   always_comb begin
      level_d = level_q;
      case ({push, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   // NOTE: the storage array is reset too; it is only a few entries and it makes
   // the head outputs read zero out of reset instead of X.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= wr_entry;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         level_q <= level_d;
      end
   end

   assign up_valid = (level_q != '0);
   assign up_data  = mem_q[rd_ptr_q].data;
   assign up_idx   = mem_q[rd_ptr_q].idx;
   assign level    = level_q;

`ifdef HIER_NODE_ARBITER_STATS_EN
   logic [STAT_W-1:0] cnt_q [N_CHILDREN];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < N_CHILDREN; c++) cnt_q[c] <= '0;
      end else if (stat_clr) begin
         for (int c = 0; c < N_CHILDREN; c++) cnt_q[c] <= '0;
      end else begin
         for (int c = 0; c < N_CHILDREN; c++) begin
            if (ch_valid[c] && ch_ready[c] && (cnt_q[c] != '1)) cnt_q[c] <= cnt_q[c] + 1'b1;
         end
      end
   end

   for (genvar g = 0; g < N_CHILDREN; g++) begin : g_stat
      assign stat_grant_cnt[g*STAT_W +: STAT_W] = cnt_q[g];
   end
`else
   logic unused_stat_clr;
   assign unused_stat_clr = stat_clr;
   assign stat_grant_cnt  = '0;
`endif

endmodule

// File: tb/tb_hier_node_arbiter.sv
// Directed bench for hier_node_arbiter (N_CHILDREN=5, DATA_W=8, DEPTH=4).
module tb_hier_node_arbiter;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic [4:0]  ch_valid;
   logic [39:0] ch_data;
   logic [4:0]  ch_ready;
   logic        up_valid;
   logic [7:0]  up_data;
   logic [2:0]  up_idx;
   logic        up_ready;
   logic [2:0]  level;
   logic        stat_clr;
   logic [79:0] stat_grant_cnt;

   int total = 0;
   int bad   = 0;

   hier_node_arbiter dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .en             (en),
      .ch_valid       (ch_valid),
      .ch_data        (ch_data),
      .ch_ready       (ch_ready),
      .up_valid       (up_valid),
      .up_data        (up_data),
      .up_idx         (up_idx),
      .up_ready       (up_ready),
      .level          (level),
      .stat_clr       (stat_clr),
      .stat_grant_cnt (stat_grant_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic set_data(input int k, input logic [7:0] v);
      ch_data[k*8 +: 8] = v;
   endtask

   initial begin
      rst_n    = 1'b0;
      en       = 1'b1;
      ch_valid = '0;
      ch_data  = '0;
      up_ready = 1'b0;
      stat_clr = 1'b0;

      // Reset then idle
      repeat (3) @(negedge clk);
      #1;
      check("rst_up_valid", 32'(up_valid), 32'd0);
      check("rst_level", 32'(level), 32'd0);
      check("rst_ch_ready", 32'(ch_ready), 32'd0);
      check("rst_up_data", 32'(up_data), 32'd0);
      check("rst_up_idx", 32'(up_idx), 32'd0);
      check("rst_stat", 32'(|stat_grant_cnt), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Fairness: all children valid, upstream always ready
      for (int k = 0; k < 5; k++) set_data(k, 8'(8'h10 + k));
      ch_valid = 5'b11111;
      up_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         #1;
         check("fair_ready", 32'(ch_ready), 32'(1) << (i % 5));
         if (i > 0) begin
            check("fair_idx", 32'(up_idx), 32'((i - 1) % 5));
            check("fair_data", 32'(up_data), 32'(8'h10 + (i - 1) % 5));
            check("fair_level", 32'(level), 32'd1);
         end
         @(negedge clk);
      end
      ch_valid = '0;
      #1;
      check("fair_last_idx", 32'(up_idx), 32'd4);
      @(negedge clk);
      #1;
      check("fair_drained", 32'(level), 32'd0);
      check("fair_up_valid", 32'(up_valid), 32'd0);

      // Full / backpressure from child 2
      up_ready = 1'b0;
      ch_valid = 5'b00100;
      for (int j = 0; j < 4; j++) begin
         set_data(2, 8'(8'hA0 + j));
         #1;
         check("full_ready", 32'(ch_ready), 32'b00100);
         if (j > 0) check("full_hold", 32'(up_data), 32'hA0);
         @(negedge clk);
      end
      set_data(2, 8'hA4);
      #1;
      check("full_level", 32'(level), 32'd4);
      check("full_no_ready", 32'(ch_ready), 32'd0);
      check("full_head", 32'(up_data), 32'hA0);
      check("full_head_idx", 32'(up_idx), 32'd2);
      up_ready = 1'b1;
      #1;
      check("full_pop_no_grant", 32'(ch_ready), 32'd0);
      @(negedge clk);
      up_ready = 1'b0;
      #1;
      check("full_after_pop", 32'(level), 32'd3);
      check("full_next_head", 32'(up_data), 32'hA1);
      check("full_regrant", 32'(ch_ready), 32'b00100);
      @(negedge clk);
      ch_valid = '0;
      up_ready = 1'b1;
      for (int j = 0; j < 4; j++) begin
         #1;
         check("full_drain", 32'(up_data), 32'(8'hA1 + j));
         @(negedge clk);
      end
      #1;
      check("full_empty", 32'(level), 32'd0);

      // Simultaneous push and pop from child 3
      up_ready = 1'b0;
      ch_valid = 5'b01000;
      set_data(3, 8'hC0);
      @(negedge clk);
      set_data(3, 8'hC1);
      @(negedge clk);
      #1;
      check("sim_level_pre", 32'(level), 32'd2);
      up_ready = 1'b1;
      for (int j = 0; j < 2; j++) begin
         set_data(3, 8'(8'hC2 + j));
         #1;
         check("sim_head", 32'(up_data), 32'(8'hC0 + j));
         check("sim_ready", 32'(ch_ready), 32'b01000);
         @(negedge clk);
         #1;
         check("sim_level", 32'(level), 32'd2);
      end
      ch_valid = '0;
      for (int j = 0; j < 2; j++) begin
         #1;
         check("sim_order", 32'(up_data), 32'(8'hC2 + j));
         @(negedge clk);
      end
      #1;
      check("sim_empty", 32'(level), 32'd0);

      // Reset mid-burst from child 0
      up_ready = 1'b0;
      ch_valid = 5'b00001;
      for (int j = 0; j < 3; j++) begin
         set_data(0, 8'(8'hD0 + j));
         @(negedge clk);
      end
      #1;
      check("mid_level", 32'(level), 32'd3);
      check("mid_valid", 32'(up_valid), 32'd1);
      ch_valid = '0;
      rst_n    = 1'b0;
      #1;
      check("mid_async_valid", 32'(up_valid), 32'd0);
      check("mid_async_level", 32'(level), 32'd0);
      check("mid_async_data", 32'(up_data), 32'd0);
      check("mid_async_ready", 32'(ch_ready), 32'd0);
      @(negedge clk);
      rst_n    = 1'b1;
      ch_valid = 5'b00011;
      set_data(0, 8'hE0);
      set_data(1, 8'hE1);
      #1;
      check("mid_first_winner", 32'(ch_ready), 32'b00001);
      @(negedge clk);

      // Enable low: no grants, FIFO drains, last grant preserved
      en       = 1'b0;
      up_ready = 1'b1;
      #1;
      check("en_off_ready", 32'(ch_ready), 32'd0);
      check("en_off_head", 32'(up_data), 32'hE0);
      @(negedge clk);
      #1;
      check("en_off_drain", 32'(level), 32'd0);
      check("en_off_ready2", 32'(ch_ready), 32'd0);
      en = 1'b1;
      #1;
      check("en_on_rotate", 32'(ch_ready), 32'b00010);
      ch_valid = '0;
      @(negedge clk);

`ifdef HIER_NODE_ARBITER_STATS_EN
      stat_clr = 1'b1;
      @(negedge clk);
      stat_clr = 1'b0;
      #1;
      check("stat_cleared", 32'(|stat_grant_cnt), 32'd0);
      ch_valid = 5'b00010;
      up_ready = 1'b1;
      set_data(1, 8'h55);
      repeat (3) @(negedge clk);
      #1;
      check("stat_cnt3", 32'(stat_grant_cnt[31:16]), 32'd3);
      repeat (70000) @(negedge clk);
      #1;
      check("stat_sat", 32'(stat_grant_cnt[31:16]), 32'hFFFF);
      check("stat_other", 32'(stat_grant_cnt[15:0]), 32'd0);
      stat_clr = 1'b1;
      @(negedge clk);
      stat_clr = 1'b0;
      #1;
      check("stat_clr_wins", 32'(stat_grant_cnt[31:16]), 32'd0);
      @(negedge clk);
      #1;
      check("stat_restart", 32'(stat_grant_cnt[31:16]), 32'd1);
      ch_valid = '0;
`else
      ch_valid = 5'b00010;
      up_ready = 1'b1;
      repeat (5) @(negedge clk);
      #1;
      check("stat_off_zero", 32'(|stat_grant_cnt), 32'd0);
      check("stat_off_flow", 32'(up_idx), 32'd1);
      ch_valid = '0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
